esp_tx_arbiter: RTL



---
 rtl/esp_tx_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/esp_tx_arbiter.sv
// rtl/esp_tx_arbiter.sv - round-robin packet arbiter sharing one UART TX byte port
// Grants whole packets, optional channel header byte, revokes a grant after a stall timeout.
module esp_tx_arbiter #(
  parameter int          NUM_REQ      = 3,
  parameter int          HEADER_EN    = 1,
  parameter logic [7:0]  HDR_BASE     = 8'hF0,
  parameter int          HOLD_TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [8*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_busy,
  output logic [2:0]             owner,
  output logic                   owner_valid,
  output logic                   timeout_pulse
);

  typedef enum logic [1:0] {IDLE, HDR, DATA} state_e;

  state_e      state_q, state_d;
  logic [2:0]  owner_q, owner_d;
  logic [2:0]  last_owner_q, last_owner_d;
  logic [15:0] stall_q, stall_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_valid_q, tx_valid_d;
  logic        timeout_q, timeout_d;

  logic        send_ok;
  logic        accept;
  logic        cur_valid, cur_last;
  logic [7:0]  cur_data;
  logic [2:0]  pick, pick_hi, pick_lo;
  logic        found_hi, found_lo;
  int          start_idx;

  // At most one strobe in flight: the UART raises busy the cycle after tx_valid.
  assign send_ok = !tx_busy && !tx_valid_q;

  // Round-robin: first valid at/after start_idx, else wrap to the lowest valid.
  always_comb begin
    start_idx = (int'(last_owner_q) >= NUM_REQ - 1) ? 0 : int'(last_owner_q) + 1;
    pick_hi   = 3'd0;
    pick_lo   = 3'd0;
    found_hi  = 1'b0;
    found_lo  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found_hi && req_valid[i] && (i >= start_idx)) begin
        found_hi = 1'b1;
        pick_hi  = 3'(i);
      end
      if (!found_lo && req_valid[i]) begin
        found_lo = 1'b1;
        pick_lo  = 3'(i);
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == 3'(i)) begin
        cur_valid = req_valid[i];
        cur_last  = req_last[i];
        cur_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    stall_d      = stall_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = 1'b0;
    timeout_d    = 1'b0;
    accept       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          owner_d = pick;
          stall_d = 16'd0;
          state_d = (HEADER_EN != 0) ? HDR : DATA;
        end
      end
      HDR: begin
        if (send_ok) begin
          tx_data_d  = HDR_BASE | {5'd0, owner_q};
          tx_valid_d = 1'b1;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (send_ok) begin
          if (cur_valid) begin
            accept     = 1'b1;
            tx_data_d  = cur_data;
            tx_valid_d = 1'b1;
            stall_d    = 16'd0;
            if (cur_last) begin
              last_owner_d = owner_q;
              state_d      = IDLE;
            end
          end else if (stall_q == 16'(HOLD_TIMEOUT - 1)) begin
            // Packet is left truncated on the wire; the receiver resyncs on the next header.
            timeout_d    = 1'b1;
            last_owner_d = owner_q;
            stall_d      = 16'd0;
            state_d      = IDLE;
          end else begin
            stall_d = stall_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = accept && (owner_q == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 3'd0;
      last_owner_q <= 3'(NUM_REQ - 1);
      stall_q      <= 16'd0;
      tx_data_q    <= 8'h00;
      tx_valid_q   <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      stall_q      <= stall_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  assign tx_data       = tx_data_q;
  assign tx_valid      = tx_valid_q;
  assign owner         = owner_q;
  assign owner_valid   = (state_q != IDLE);
  assign timeout_pulse = timeout_q;

endmodule
